// File: rtl/selevy_dbgdump.sv
// selevy_dbgdump: halts the selevy core, then streams register-file and/or RAM
// words MSB-first as OUT_W-bit digits on gout, each qualified by an out_clk pulse.
module selevy_dbgdump #(
    parameter int XLEN      = 32,
    parameter int REG_NUM   = 32,
    parameter int MEM_DEPTH = 64,
    parameter int OUT_W     = 4,
    parameter int CLK_DIV   = 1,
    localparam int RA_W     = (REG_NUM > 1) ? $clog2(REG_NUM) : 1,
    localparam int MA_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            start,
    input  logic            sel_rf,
    input  logic            sel_mem,
    output logic            halt_req,
    input  logic            halt_ack,
    output logic [RA_W-1:0] rf_addr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic [MA_W-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [OUT_W-1:0] gout,
    output logic            out_clk,
    output logic            busy,
    output logic            done,
    output logic            abort
);

    localparam int ND    = XLEN / OUT_W;
    localparam int IDX_W = (RA_W > MA_W) ? RA_W : MA_W;
    localparam int CNT_W = $clog2(2 * CLK_DIV + 1);
    localparam int DIG_W = $clog2(ND + 1);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(ND - 1);
    localparam logic [IDX_W-1:0] RF_LAST  = IDX_W'(REG_NUM - 1);
    localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_DEPTH - 1);
    localparam logic [OUT_W-1:0] TAG_RF   = OUT_W'(4'hA);
    localparam logic [OUT_W-1:0] TAG_MEM  = OUT_W'(4'hB);

    generate
        if (XLEN % OUT_W != 0) begin : g_bad_out_w
            $error("selevy_dbgdump: XLEN must be a multiple of OUT_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_HALT, S_TAG, S_RD, S_CAP, S_SHIFT, S_DONE
    } state_t;

    state_t           state, state_n;
    logic             lat_rf, lat_mem;
    logic             sec_mem;          // 0: register-file section, 1: RAM section
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [DIG_W-1:0] dig;
    logic [XLEN-1:0]  shreg;

    logic             halt_lost;
    logic             period_end;
    logic             word_end;
    logic [IDX_W-1:0] idx_last;
    logic [XLEN-1:0]  rdata;

    assign halt_lost  = !halt_ack && (state inside {S_TAG, S_RD, S_CAP, S_SHIFT});
    assign period_end = (cnt == LAST_CNT);
    assign word_end   = period_end && (dig == LAST_DIG);
    assign idx_last   = sec_mem ? MEM_LAST : RF_LAST;
    assign rdata      = sec_mem ? mem_rdata : rf_rdata;
    assign rf_addr    = RA_W'(idx);
    assign mem_addr   = MA_W'(idx);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // NOTE: state_n gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_n = state;
        if (halt_lost) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start && (sel_rf || sel_mem)) state_n = S_HALT;
                S_HALT:  if (halt_ack) state_n = S_TAG;
                S_TAG:   if (period_end) state_n = S_RD;
                S_RD:    state_n = S_CAP;
                S_CAP:   state_n = S_SHIFT;
                S_SHIFT: begin
                    if (word_end) begin
                        if (idx < idx_last)          state_n = S_RD;
                        else if (!sec_mem && lat_mem) state_n = S_TAG;
                        else                          state_n = S_DONE;
                    end
                end
                S_DONE:  state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        halt_req = (state != S_IDLE);
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            lat_rf  <= 1'b0;
            lat_mem <= 1'b0;
            sec_mem <= 1'b0;
            idx     <= '0;
            cnt     <= '0;
            dig     <= '0;
            shreg   <= '0;
            gout    <= '0;
            out_clk <= 1'b0;
            abort   <= 1'b0;
        end else begin
            abort <= 1'b0;
            if (halt_lost) begin
                abort   <= 1'b1;
                gout    <= '0;
                out_clk <= 1'b0;
                lat_rf  <= 1'b0;
                lat_mem <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && (sel_rf || sel_mem)) begin
                            lat_rf  <= sel_rf;
                            lat_mem <= sel_mem;
                        end
                    end
                    S_HALT: begin
                        if (halt_ack) begin
                            sec_mem <= !lat_rf;
                            idx     <= '0;
                            cnt     <= '0;
                            gout    <= lat_rf ? TAG_RF : TAG_MEM;
                            out_clk <= 1'b0;
                        end
                    end
                    S_TAG: begin
                        if (period_end) begin
                            cnt     <= '0;
                            out_clk <= 1'b0;
                        end else begin
                            cnt     <= cnt + CNT_W'(1);
                            out_clk <= (cnt >= HALF_M1);
                        end
                    end
                    S_CAP: begin
                        // First digit goes straight out while the rest waits in the shifter.
                        gout    <= rdata[XLEN-1 -: OUT_W];
                        shreg   <= rdata << OUT_W;
                        dig     <= '0;
                        cnt     <= '0;
                        out_clk <= 1'b0;
                    end
                    S_SHIFT: begin
                        if (!period_end) begin
                            cnt     <= cnt + CNT_W'(1);
                            out_clk <= (cnt >= HALF_M1);
                        end else begin
                            cnt     <= '0;
                            out_clk <= 1'b0;
                            if (dig != LAST_DIG) begin
                                gout  <= shreg[XLEN-1 -: OUT_W];
                                shreg <= shreg << OUT_W;
                                dig   <= dig + DIG_W'(1);
                            end else if (idx < idx_last) begin
                                idx <= idx + IDX_W'(1);
                            end else if (!sec_mem && lat_mem) begin
                                sec_mem <= 1'b1;
                                idx     <= '0;
                                gout    <= TAG_MEM;
                            end
                        end
                    end
                    S_DONE: begin
                        gout    <= '0;
                        out_clk <= 1'b0;
                        lat_rf  <= 1'b0;
                        lat_mem <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_selevy_dbgdump.sv
// Bench for selevy_dbgdump: two instances (CLK_DIV=1 and 2) sharing a small rf/ram model;
// a digit scoreboard is filled by the stimulus and drained by an out_clk monitor.
module tb_selevy_dbgdump;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        start_a [2];
    logic        sel_rf = 1'b0, sel_mem = 1'b0, halt_ack = 1'b0;
    logic        halt_req_a [2], busy_a [2], done_a [2], abort_a [2], oc_a [2];
    logic [3:0]  gout_a [2];
    logic [1:0]  rf_addr_a [2];
    logic [0:0]  mem_addr_a [2];
    logic [31:0] rf_rd_a [2], mem_rd_a [2];
    logic [31:0] rf_m [4];
    logic [31:0] ram_m [2];

    logic [3:0]  exp_q [2][$];
    int          run_a [2];
    logic        prev_a [2];
    logic [3:0]  held_a [2];
    int          n_checks = 0, n_pass = 0;

    always #5 CLK = ~CLK;

    selevy_dbgdump #(.XLEN(32), .REG_NUM(4), .MEM_DEPTH(2), .OUT_W(4), .CLK_DIV(1)) u_dut0 (
        .CLK(CLK), .reset(reset), .start(start_a[0]), .sel_rf(sel_rf), .sel_mem(sel_mem),
        .halt_req(halt_req_a[0]), .halt_ack(halt_ack),
        .rf_addr(rf_addr_a[0]), .rf_rdata(rf_rd_a[0]),
        .mem_addr(mem_addr_a[0]), .mem_rdata(mem_rd_a[0]),
        .gout(gout_a[0]), .out_clk(oc_a[0]), .busy(busy_a[0]), .done(done_a[0]), .abort(abort_a[0])
    );

    selevy_dbgdump #(.XLEN(32), .REG_NUM(4), .MEM_DEPTH(2), .OUT_W(4), .CLK_DIV(2)) u_dut1 (
        .CLK(CLK), .reset(reset), .start(start_a[1]), .sel_rf(sel_rf), .sel_mem(sel_mem),
        .halt_req(halt_req_a[1]), .halt_ack(halt_ack),
        .rf_addr(rf_addr_a[1]), .rf_rdata(rf_rd_a[1]),
        .mem_addr(mem_addr_a[1]), .mem_rdata(mem_rd_a[1]),
        .gout(gout_a[1]), .out_clk(oc_a[1]), .busy(busy_a[1]), .done(done_a[1]), .abort(abort_a[1])
    );

    // Synchronous read model: data valid one cycle after the address.
    always @(posedge CLK) begin
        for (int d = 0; d < 2; d++) begin
            rf_rd_a[d]  <= rf_m[rf_addr_a[d]];
            mem_rd_a[d] <= ram_m[mem_addr_a[d]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: digit on each out_clk rise, gout stable while high, high phase CLK_DIV cycles long.
    always @(negedge CLK) begin
        for (int d = 0; d < 2; d++) begin
            if (oc_a[d] && !prev_a[d]) begin
                if (exp_q[d].size() == 0)
                    check($sformatf("dut%0d_extra_digit_queue", d), 0, 1);
                else
                    check($sformatf("dut%0d_digit", d), {28'd0, gout_a[d]}, {28'd0, exp_q[d].pop_front()});
                held_a[d] = gout_a[d];
                run_a[d]  = 1;
            end else if (oc_a[d] && prev_a[d]) begin
                check($sformatf("dut%0d_gout_stable", d), {28'd0, gout_a[d]}, {28'd0, held_a[d]});
                run_a[d]++;
            end else if (!oc_a[d] && prev_a[d]) begin
                check($sformatf("dut%0d_high_len", d), run_a[d], (d == 0) ? 1 : 2);
            end
            prev_a[d] = oc_a[d];
        end
    end

    task automatic push_word(input int d, input logic [31:0] w);
        for (int i = 0; i < 8; i++) exp_q[d].push_back(w[31 - 4 * i -: 4]);
    endtask

    task automatic push_dump(input int d, input logic srf, input logic smem);
        if (srf) begin
            exp_q[d].push_back(4'hA);
            for (int i = 0; i < 4; i++) push_word(d, rf_m[i]);
        end
        if (smem) begin
            exp_q[d].push_back(4'hB);
            for (int i = 0; i < 2; i++) push_word(d, ram_m[i]);
        end
    endtask

    // Issue start, raise halt_ack 3 cycles after halt_req; returns at the negedge after edge E0.
    task automatic kick(input int d, input logic srf, input logic smem);
        @(negedge CLK);
        sel_rf = srf; sel_mem = smem; start_a[d] = 1'b1;
        @(negedge CLK);
        start_a[d] = 1'b0; sel_rf = 1'b0; sel_mem = 1'b0;
        check($sformatf("dut%0d_halt_req_on", d), halt_req_a[d], 1);
        check($sformatf("dut%0d_busy_on", d), busy_a[d], 1);
        repeat (2) @(negedge CLK);
        halt_ack = 1'b1;
        @(posedge CLK);
    endtask

    task automatic run_dump(input int d, input logic srf, input logic smem,
                            input int exp_lat, input int poke_at);
        int k = 0;
        bit got = 0;
        push_dump(d, srf, smem);
        kick(d, srf, smem);
        while (!got && k < 1000) begin
            @(posedge CLK);
            k++;
            @(negedge CLK);
            start_a[d] = (k == poke_at);
            sel_rf     = (k == poke_at);
            sel_mem    = (k == poke_at);
            if (done_a[d]) got = 1;
        end
        start_a[d] = 1'b0; sel_rf = 1'b0; sel_mem = 1'b0;
        check($sformatf("dut%0d_done_latency", d), k, exp_lat);
        check($sformatf("dut%0d_halt_req_in_done", d), halt_req_a[d], 1);
        @(negedge CLK);
        check($sformatf("dut%0d_idle_after_done", d),
              {halt_req_a[d], busy_a[d], done_a[d], oc_a[d], gout_a[d]}, 0);
        check($sformatf("dut%0d_digits_left", d), exp_q[d].size(), 0);
        halt_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   k;
        bit   done_seen;
        start_a[0] = 1'b0; start_a[1] = 1'b0;
        prev_a[0] = 1'b0;  prev_a[1] = 1'b0;
        run_a[0] = 0;      run_a[1] = 0;
        rf_m[0] = 32'h0000_0000; rf_m[1] = 32'h1234_5678;
        rf_m[2] = 32'hDEAD_BEEF; rf_m[3] = 32'hFFFF_FFFF;
        ram_m[0] = 32'h0000_000F; ram_m[1] = 32'hA000_0000;

        // Reset held, then 100 idle cycles.
        repeat (3) @(negedge CLK);
        for (int d = 0; d < 2; d++)
            check($sformatf("dut%0d_reset_outs", d),
                  {halt_req_a[d], busy_a[d], done_a[d], abort_a[d], oc_a[d], gout_a[d],
                   rf_addr_a[d], mem_addr_a[d]}, 0);
        reset = 1'b1;
        acc = 1'b0;
        repeat (100) begin
            @(negedge CLK);
            acc = acc | halt_req_a[0] | busy_a[0] | done_a[0] | abort_a[0] | oc_a[0] | (|gout_a[0]);
        end
        check("idle_100_cycles", acc, 0);

        // Plain register-file dump.
        run_dump(0, 1'b1, 1'b0, 74, -1);

        // Start with no section selected is ignored.
        @(negedge CLK);
        start_a[0] = 1'b1;
        @(negedge CLK);
        start_a[0] = 1'b0;
        acc = halt_req_a[0] | busy_a[0];
        repeat (3) begin
            @(negedge CLK);
            acc = acc | halt_req_a[0] | busy_a[0];
        end
        check("empty_sel_ignored", acc, 0);

        // Start pulsed mid-dump must not disturb the stream or the done timing.
        run_dump(0, 1'b1, 1'b0, 74, 30);

        // Both sections with CLK_DIV=2.
        run_dump(1, 1'b1, 1'b1, 212, -1);

        // Abort: drop halt_ack while the third word's third digit is high.
        exp_q[0].push_back(4'hA);
        push_word(0, rf_m[0]);
        push_word(0, rf_m[1]);
        exp_q[0].push_back(4'hD); exp_q[0].push_back(4'hE); exp_q[0].push_back(4'hA);
        kick(0, 1'b1, 1'b0);
        done_seen = 0;
        k = 0;
        while (k < 45) begin
            @(posedge CLK);
            k++;
            @(negedge CLK);
            if (done_a[0]) done_seen = 1;
        end
        halt_ack = 1'b0;
        @(negedge CLK);
        check("abort_pulse", abort_a[0], 1);
        check("abort_outs_low", {halt_req_a[0], busy_a[0], oc_a[0], gout_a[0]}, 0);
        if (done_a[0]) done_seen = 1;
        @(negedge CLK);
        check("abort_one_cycle", abort_a[0], 0);
        if (done_a[0]) done_seen = 1;
        check("abort_no_done", done_seen, 0);
        check("abort_digits_left", exp_q[0].size(), 0);
        run_dump(0, 1'b1, 1'b0, 74, -1);

        // Asynchronous reset between edges, mid-SHIFT.
        push_dump(0, 1'b1, 1'b0);
        kick(0, 1'b1, 1'b0);
        repeat (30) @(negedge CLK);
        #2 reset = 1'b0;
        #1;
        check("async_reset_outs",
              {halt_req_a[0], busy_a[0], done_a[0], abort_a[0], oc_a[0], gout_a[0], rf_addr_a[0]}, 0);
        exp_q[0].delete();
        halt_ack = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        acc = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            acc = acc | halt_req_a[0] | busy_a[0] | done_a[0] | abort_a[0];
        end
        check("idle_after_reset", acc, 0);
        run_dump(0, 1'b1, 1'b0, 74, -1);

        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/selevy_dbgdump.md
Name: selevy_dbgdump

Overview:
- Parametrised hardware state-dump engine for the selevy core.
- On a start pulse it halts the core through a request/acknowledge handshake, then reads the register file and/or data RAM word by word.
- Each word is streamed MSB-first as OUT_W-bit digits on gout, qualified by out_clk.
- Used for on-board inspection of rf/ram contents; the downstream consumer samples gout on the rising edge of out_clk.

Parameters:
XLEN, 32, data word width of register file and RAM
REG_NUM, 32, number of register-file entries dumped (index 0..REG_NUM-1)
MEM_DEPTH, 64, number of RAM words dumped (index 0..MEM_DEPTH-1), >=1
OUT_W, 4, digit width on gout; XLEN % OUT_W must be 0 (elaboration error otherwise)
CLK_DIV, 1, CLK cycles per out_clk half-period, >=1

Ports:
CLK  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a dump
sel_rf  in  1  include register-file section (sampled with start)
sel_mem  in  1  include RAM section (sampled with start)
halt_req  out  1  request core stall
halt_ack  in  1  core stalled; must remain high for the whole dump
rf_addr  out  $clog2(REG_NUM)  register read index
rf_rdata  in  XLEN  register read data, valid 1 cycle after rf_addr
mem_addr  out  $clog2(MEM_DEPTH)  RAM word index
mem_rdata  in  XLEN  RAM read data, valid 1 cycle after mem_addr
gout  out  OUT_W  current output digit
out_clk  out  1  digit strobe
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse on successful completion
abort  out  1  one-cycle pulse if halt_ack drops mid-dump

Behaviour:
- Reset (reset=0, async): state IDLE; halt_req, gout, out_clk, busy, done, abort, rf_addr, mem_addr all 0; sel latches cleared.
- IDLE: start=1 with (sel_rf|sel_mem)=1 latches the sel bits, sets busy and halt_req, and moves to HALT. A start with both sels 0, or any start while busy, is ignored.
- HALT: waits with halt_req=1. The first cycle halt_ack is sampled high moves to TAG of the first selected section (rf before mem).
- Digit period: 2*CLK_DIV cycles.
  - First CLK_DIV cycles: out_clk=0, gout holds the new digit.
  - Next CLK_DIV cycles: out_clk=1, gout unchanged.
  - gout changes only when out_clk is 0.
- TAG: one digit period emitting the section tag, zero-extended/truncated to OUT_W: 4'hA for rf, 4'hB for mem. Index is cleared to 0.
- RD (1 cycle): drives rf_addr/mem_addr = index; out_clk=0, gout holds its last value.
- CAP (1 cycle): loads rf_rdata/mem_rdata into a shift register.
- SHIFT: emits XLEN/OUT_W digits, most significant first, one per digit period.
  - After the last digit: if index < last, index++ and go to RD.
  - Otherwise go to TAG of the next selected section, or to DONE.
- Per-word cost: 2 + (XLEN/OUT_W)*2*CLK_DIV cycles.
- Section cost: 2*CLK_DIV + N*per-word.
- DONE (1 cycle): done=1; halt_req, busy, out_clk, gout drop to 0 on the next edge; return to IDLE.
- halt_ack=0 in any state after HALT: next cycle abort=1, halt_req=0, busy=0, gout=0, out_clk=0, state IDLE, done not pulsed.
- start while busy: no effect, no restart.
- Index wrap: index never exceeds N-1 and never wraps within a section.
- Async reset mid-dump: all outputs to reset values immediately, no done/abort pulse.

Test Plan:
- Reset then idle: reset held 0 → all outputs 0. reset=1 with no start → outputs stay 0 for 100 cycles.
- RF dump: XLEN=32, OUT_W=4, CLK_DIV=1, REG_NUM=4, rf={0x00000000,0x12345678,0xDEADBEEF,0xFFFFFFFF}, start with sel_rf=1/sel_mem=0, halt_ack raised 3 cycles after halt_req → stream is A, 0×8, 1..8, D,E,A,D,B,E,E,F, F×8. done pulses exactly 74 cycles after the first CLK edge with halt_ack sampled high (TAG 2 + 4×18). halt_req falls next cycle.
- Both sections with CLK_DIV=2, MEM_DEPTH=2, ram={0x0000000F,0xA0000000} → tag B follows the last rf digit. Each out_clk half-period is 2 cycles, and gout is stable across every out_clk rising edge.
- Abort: drop halt_ack during the 3rd word's SHIFT → abort=1 for one cycle, done never asserts, busy/halt_req=0. A following start performs a complete dump.
- Ignored starts: start with sel_rf=sel_mem=0 → no halt_req. start pulsed mid-dump → digit sequence and done timing identical to the undisturbed run.
- Async reset assertion between CLK edges mid-SHIFT → outputs 0 before the next edge. After release, the block is in IDLE.
